// File: rtl/pds_switch.sv
// N-port packet switch: per-input FIFO plus header-steered head FSM, per-output
// packet-locked round-robin arbiter. Illegal-destination packets are dropped and counted.

module pds_in_port #(
  parameter int NPORTS = 4,
  parameter int DW     = 8,
  parameter int DEPTH  = 8,
  parameter int PW     = 2
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ready_en,
  input  logic              in_valid,
  input  logic [DW-1:0]     in_data,
  input  logic              in_last,
  output logic              in_ready,
  input  logic              gnt,
  input  logic              fwd_pop,
  output logic [NPORTS-1:0] req,
  output logic [DW-1:0]     head_data,
  output logic              head_last,
  output logic              head_vld,
  output logic [7:0]        drop_count
);
  localparam int AW = $clog2(DEPTH);

  typedef enum logic [2:0] {IDLE, HDR, REQ, FWD, DROP} state_e;

  logic [DW:0]    mem_q [DEPTH];
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]    cnt_q, cnt_d;
  state_e         state_q, state_d;
  logic [PW-1:0]  dest_q, dest_d, head_dest;
  logic [7:0]     drop_q, drop_d;
  logic           push, pop, full, empty, legal;

  assign full       = cnt_q == (AW+1)'(DEPTH);
  assign empty      = cnt_q == '0;
  assign in_ready   = ready_en && !full;
  assign push       = in_valid && in_ready;
  assign head_data  = mem_q[rd_ptr_q][DW-1:0];
  assign head_last  = mem_q[rd_ptr_q][DW];
  assign head_vld   = !empty;
  assign head_dest  = head_data[PW-1:0];
  assign legal      = (PW+1)'(head_dest) < (PW+1)'(NPORTS);
  assign drop_count = drop_q;

  always_comb begin
    state_d = state_q;
    dest_d  = dest_q;
    drop_d  = drop_q;
    req     = '0;
    pop     = 1'b0;
    case (state_q)
      IDLE: if (!empty) state_d = HDR;
      HDR: begin
        if (legal) begin
          req[head_dest] = 1'b1;
          dest_d         = head_dest;
          state_d        = REQ;
        end else begin
          if (drop_q != 8'hFF) drop_d = drop_q + 8'd1;
          state_d = DROP;
        end
      end
      REQ: begin
        // Request held while the grant is pending; the granted cycle may already pop.
        req[dest_q] = 1'b1;
        pop         = fwd_pop;
        if (gnt) state_d = FWD;
      end
      FWD:     pop = fwd_pop;
      DROP:    pop = !empty;
      default: state_d = IDLE;
    endcase
    wr_ptr_d = wr_ptr_q + AW'(push);
    rd_ptr_d = rd_ptr_q + AW'(pop);
    cnt_d    = cnt_q + (AW+1)'(push) - (AW+1)'(pop);
    // Next head after a last word is a fresh header; skip IDLE when one is already queued.
    if (pop && head_last) state_d = (cnt_d != '0) ? HDR : IDLE;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      dest_q   <= '0;
      drop_q   <= '0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      dest_q   <= dest_d;
      drop_q   <= drop_d;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (push) mem_q[wr_ptr_q] <= {in_last, in_data};
  end
endmodule

module pds_switch #(
  parameter int NPORTS = 4,
  parameter int DW     = 8,
  parameter int DEPTH  = 8
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NPORTS-1:0]    in_valid,
  output logic [NPORTS-1:0]    in_ready,
  input  logic [NPORTS*DW-1:0] in_data,
  input  logic [NPORTS-1:0]    in_last,
  output logic [NPORTS-1:0]    out_valid,
  input  logic [NPORTS-1:0]    out_ready,
  output logic [NPORTS*DW-1:0] out_data,
  output logic [NPORTS-1:0]    out_last,
  output logic [NPORTS*8-1:0]  drop_count
);
  localparam int PW = $clog2(NPORTS);

  logic                           ready_en_q, ready_en_d;
  logic [NPORTS-1:0][NPORTS-1:0]  req;     // [input][output]
  logic [NPORTS-1:0][NPORTS-1:0]  own_t;   // [input][output]: output locked to input
  logic [NPORTS-1:0][NPORTS-1:0]  pop_t;   // [input][output]: output transfers from input
  logic [NPORTS-1:0][DW-1:0]      head_data;
  logic [NPORTS-1:0]              head_last, head_vld, gnt, fwd_pop;

  assign ready_en_d = 1'b1;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) ready_en_q <= 1'b0;
    else        ready_en_q <= ready_en_d;
  end

  for (genvar i = 0; i < NPORTS; i++) begin : g_port
    assign gnt[i]     = |own_t[i];
    assign fwd_pop[i] = |pop_t[i];

    pds_in_port #(.NPORTS(NPORTS), .DW(DW), .DEPTH(DEPTH), .PW(PW)) u_port (
      .clk        (clk),
      .rst_n      (rst_n),
      .ready_en   (ready_en_q),
      .in_valid   (in_valid[i]),
      .in_data    (in_data[i*DW +: DW]),
      .in_last    (in_last[i]),
      .in_ready   (in_ready[i]),
      .gnt        (gnt[i]),
      .fwd_pop    (fwd_pop[i]),
      .req        (req[i]),
      .head_data  (head_data[i]),
      .head_last  (head_last[i]),
      .head_vld   (head_vld[i]),
      .drop_count (drop_count[i*8 +: 8])
    );
  end

  for (genvar j = 0; j < NPORTS; j++) begin : g_out
    logic              lock_q, lock_d, xfer;
    logic [PW-1:0]     gsel_q, gsel_d, rr_q, rr_d;
    logic [PW:0]       idx;
    logic [NPORTS-1:0] col;

    assign out_valid[j]            = lock_q && head_vld[gsel_q];
    assign out_data[j*DW +: DW]    = out_valid[j] ? head_data[gsel_q] : '0;
    assign out_last[j]             = out_valid[j] && head_last[gsel_q];
    assign xfer                    = out_valid[j] && out_ready[j];

    for (genvar i = 0; i < NPORTS; i++) begin : g_col
      assign col[i]      = req[i][j];
      assign own_t[i][j] = lock_q && (gsel_q == PW'(i));
      assign pop_t[i][j] = own_t[i][j] && xfer;
    end

    always_comb begin
      lock_d = lock_q;
      gsel_d = gsel_q;
      rr_d   = rr_q;
      idx    = '0;
      if (lock_q) begin
        if (xfer && out_last[j]) begin
          lock_d = 1'b0;
          rr_d   = (gsel_q == PW'(NPORTS-1)) ? '0 : gsel_q + PW'(1);
        end
      end else begin
        // Scan farthest-first so the requester nearest the pointer wins.
        for (int k = NPORTS-1; k >= 0; k--) begin
          idx = {1'b0, rr_q} + (PW+1)'(k);
          if (idx >= (PW+1)'(NPORTS)) idx = idx - (PW+1)'(NPORTS);
          if (col[idx[PW-1:0]]) begin
            lock_d = 1'b1;
            gsel_d = idx[PW-1:0];
          end
        end
      end
    end

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        lock_q <= 1'b0;
        gsel_q <= '0;
        rr_q   <= '0;
      end else begin
        lock_q <= lock_d;
        gsel_q <= gsel_d;
        rr_q   <= rr_d;
      end
    end
  end
endmodule

// File: doc/pds_switch.md
# pds_switch

Parametrised N-port packet switch for the pds packet stream: the DUT that sits between the pds_if port agents in the class-based testbench. Each input port buffers incoming words in a private FIFO, routes each packet by the destination field of its header word, and forwards it whole to one output port. Round-robin arbitration per output, packet-locked (no interleaving), with illegal-destination packets dropped and counted.

## Interface
- NPORTS, 4, number of input and output ports (2..8)
- DW, 8, data word width; header destination field is data[PW-1:0], PW = $clog2(NPORTS)
- DEPTH, 8, words per input FIFO (power of two, >= 2)
- clock  in  1  single clock, rising edge
- reset  in  1  asynchronous, active-low reset
- in_valid  in  NPORTS  word valid per input port
- in_ready  out  NPORTS  input FIFO can accept a word
- in_data  in  NPORTS*DW  input words, port i at [i*DW +: DW]
- in_last  in  NPORTS  word is last of packet
- out_valid  out  NPORTS  word valid per output port
- out_ready  in  NPORTS  sink accepts word
- out_data  out  NPORTS*DW  output words, port j at [j*DW +: DW]
- out_last  out  NPORTS  word is last of packet
- drop_count  out  NPORTS*8  per-input dropped-packet counter, saturating

## Operation
- Transfer on any port = valid && ready at a rising clock edge. First word after reset or after a last is the header; header is forwarded unchanged as word 0 of the packet.
- Input FIFO i stores {last, data}. in_ready[i] = !full[i] && ready_en; ready_en is a flop, 0 in reset, 1 from the first edge after reset release. Full FIFO refuses a push even if a pop occurs the same cycle.
- Per-input head FSM:
  - IDLE: FIFO empty. Go HDR when non-empty.
  - HDR: head is a header. dest < NPORTS -> raise req[i][dest], go REQ. dest >= NPORTS -> increment drop_count[i] (saturate at 255), go DROP.
  - REQ: hold request until granted -> FWD.
  - FWD: pop head whenever out_ready[dest] and head valid; popping the last word -> IDLE (or HDR if FIFO still non-empty).
  - DROP: pop one word per cycle while non-empty, drive nothing; popping last word -> IDLE/HDR.
- Per-output arbiter j: when unlocked, grant the first requesting input at or after pointer rr[j] (wrapping modulo NPORTS); grant is registered and locks output j. Lock releases on the edge transferring out_last; rr[j] then becomes granted+1 mod NPORTS. Rest of packet streams one word per cycle with no bubbles while FIFO non-empty and out_ready high.
- out_valid[j] = locked && granted FIFO non-empty; out_data/out_last muxed from granted FIFO head; 0 when not valid.
- Packets from one input to one output preserve order; different inputs to different outputs proceed concurrently.

## Timing
- Reset (async assert): FIFOs emptied, FSMs IDLE, locks cleared, rr = 0, drop_count = 0; in_ready = 0, out_valid = 0, out_data = 0, out_last = 0 immediately. Reset mid-packet discards all partial packets; no output resumes after release until a fresh header arrives.
- Latency: header accepted at edge E0 -> at FIFO head after E0 -> HDR evaluated, request raised after E1 -> grant registered at E2 -> out_valid high in the cycle after E2 (2-edge minimum from accept to out_valid visible... header reaches output 3 edges after acceptance including the output transfer edge E3 at earliest).
- Throughput: 1 word/cycle per output once locked; single-word packet (header with last=1) releases lock on its own transfer edge, next grant registered on the following edge (1 idle cycle between packets on an output).
- out_ready low: out_valid/out_data held stable until transfer.
- Drop: 1 word discarded per cycle; drop_count updates the edge after the header reaches HDR.

## Test plan
- Single packet: port0 sends header 0x02, payload 0xA1, 0xA2 (last) -> out port2 shows 0x02, 0xA1, 0xA2 with out_last on 0xA2, out_valid first high 3rd cycle after accept; other outputs idle.
- Contention: ports 0,1,3 each send 4-word packets to dest 1 simultaneously -> output 1 delivers whole packets in order 0,1,3, never interleaved; repeat burst -> order 0,1,3 resumes from rr = 0 (after 3 -> 0).
- Backpressure/full: out_ready[2]=0, port0 pushes 9 words to dest 2 with DEPTH=8 -> in_ready[0] drops after 8 accepted; release out_ready -> all 9 delivered intact.
- Illegal dest with NPORTS=6: header 0x07 plus 2 payload words -> nothing on any output, drop_count[0] = 1; 300 such packets -> saturates at 255.
- Concurrency: port0->3 and port1->2 simultaneously -> both outputs stream 1 word/cycle in parallel.
- Reset mid-packet: assert reset during word 2 of a 5-word packet -> outputs 0 immediately; after release in_ready rises one edge later, new packet forwarded correctly, no residual words.
